// File: rtl/cpu_joypad_port_pkg.sv
// Shared types and constants for the NES controller port responder ($4016/$4017).
package cpu_joypad_port_pkg;

    typedef logic [7:0] data_logic_t;

    localparam logic [15:0] JOY_ADDR_P1     = 16'h4016;
    localparam logic [15:0] JOY_ADDR_P2     = 16'h4017;
    localparam data_logic_t JOY_OPEN_BUS    = 8'h40;
    localparam int          JOY_SYNC_STAGES = 2;

    localparam int                   JOY_COUNT_W   = 4;
    localparam logic [JOY_COUNT_W-1:0] JOY_COUNT_MAX = 4'd8;

    // First member lands in the MSB, so A ends up at bit 0 as on the wire.
    typedef struct packed {
        logic right;
        logic left;
        logic down;
        logic up;
        logic start;
        logic select;
        logic b;
        logic a;
    } joy_buttons_t;

    function automatic logic [JOY_COUNT_W-1:0] joy_count_inc(input logic [JOY_COUNT_W-1:0] count);
        return (count >= JOY_COUNT_MAX) ? JOY_COUNT_MAX : count + JOY_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/cpu_joypad_port_shifter.sv
// One controller port: button synchroniser, serial shift register, read counter
// and access-start detection so a held read strobe shifts only once.
module cpu_joypad_port_shifter
    import cpu_joypad_port_pkg::*;
#(
    parameter int SYNC_STAGES = JOY_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         reset,
    input  joy_buttons_t buttons,
    input  logic         strobe,
    input  logic         sel,
    output logic         serial_bit
);

    joy_buttons_t           sync_q [SYNC_STAGES];
    joy_buttons_t           synced;
    data_logic_t            shift_q;
    logic [JOY_COUNT_W-1:0] count_q;
    logic                   prev_sel_q;
    logic                   access_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= buttons;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced       = sync_q[SYNC_STAGES-1];
    assign access_start = sel & ~prev_sel_q;

    // While strobe is high the register follows the pads; the load on the last
    // strobe-high cycle is the snapshot that later reads walk through.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            count_q    <= '0;
            prev_sel_q <= 1'b0;
        end else begin
            prev_sel_q <= sel;
            if (strobe) begin
                shift_q <= synced;
                count_q <= '0;
            end else if (access_start) begin
                shift_q <= {1'b1, shift_q[7:1]};
                count_q <= joy_count_inc(count_q);
            end
        end
    end

    always_comb begin
        serial_bit = 1'b1;
        if (strobe) begin
            serial_bit = synced.a;
        end else if (count_q < JOY_COUNT_MAX) begin
            serial_bit = shift_q[0];
        end
    end

endmodule

// File: rtl/cpu_joypad_port.sv
// CPU-bus responder for both controller ports: address decode, strobe register,
// read data mux. A write in the same cycle as a read wins and suppresses the read.
module cpu_joypad_port
    import cpu_joypad_port_pkg::*;
#(
    parameter logic [15:0] ADDR_P1     = JOY_ADDR_P1,
    parameter logic [15:0] ADDR_P2     = JOY_ADDR_P2,
    parameter data_logic_t OPEN_BUS    = JOY_OPEN_BUS,
    parameter int          SYNC_STAGES = JOY_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  addr,
    input  data_logic_t  data_in,
    input  logic         bus_we,
    input  logic         bus_oe,
    output data_logic_t  data_out,
    output logic         data_oe,
    input  joy_buttons_t pad1_buttons,
    input  joy_buttons_t pad2_buttons
);

    logic hit_p1;
    logic hit_p2;
    logic rd_p1;
    logic rd_p2;
    logic strobe_q;
    logic bit_p1;
    logic bit_p2;
    logic unused_data_bits;

    assign hit_p1 = (addr == ADDR_P1);
    assign hit_p2 = (addr == ADDR_P2);
    assign rd_p1  = bus_oe & ~bus_we & ~reset & hit_p1;
    assign rd_p2  = bus_oe & ~bus_we & ~reset & hit_p2;

    // Only bit 0 of a $4016 write is meaningful; $4017 writes belong to the APU.
    assign unused_data_bits = ^data_in[7:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q <= 1'b0;
        end else if (bus_we & hit_p1) begin
            strobe_q <= data_in[0];
        end
    end

    cpu_joypad_port_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_pad1 (
        .clk        (clk),
        .reset      (reset),
        .buttons    (pad1_buttons),
        .strobe     (strobe_q),
        .sel        (rd_p1),
        .serial_bit (bit_p1)
    );

    cpu_joypad_port_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_pad2 (
        .clk        (clk),
        .reset      (reset),
        .buttons    (pad2_buttons),
        .strobe     (strobe_q),
        .sel        (rd_p2),
        .serial_bit (bit_p2)
    );

    always_comb begin
        data_out = '0;
        data_oe  = 1'b0;
        if (rd_p1) begin
            data_out = {OPEN_BUS[7:1], bit_p1};
            data_oe  = 1'b1;
        end else if (rd_p2) begin
            data_out = {OPEN_BUS[7:1], bit_p2};
            data_oe  = 1'b1;
        end
    end

endmodule
